logic_gate_pipe: RTL and testbench

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

---
 rtl/logic_gate_pkg.sv | 32 +++
 rtl/logic_gate_fifo2.sv | 55 +++++
 rtl/logic_gate_pipe.sv | 95 +++++++++
 tb/tb_logic_gate_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the bitwise gate pipeline: op encodings and the result record.
package logic_gate_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [2:0] {
    OpAnd   = 3'b000,
    OpOr    = 3'b001,
    OpXor   = 3'b010,
    OpNand  = 3'b011,
    OpNor   = 3'b100,
    OpXnor  = 3'b101,
    OpNotA  = 3'b110,
    OpPassA = 3'b111
  } op_e;

  typedef struct packed {
    logic [MaxWidth-1:0] y;
    logic                y_zero;
    logic                y_par;
  } result_t;

  // Callers zero-extend narrower results, so the flags match the narrow value.
  function automatic result_t make_result(logic [MaxWidth-1:0] y);
    result_t r;
    r.y      = y;
    r.y_zero = ~|y;
    r.y_par  = ^y;
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_fifo2.sv
// Two-entry result buffer; entry 0 is always the head so an empty buffer shows entry 0.
module logic_gate_fifo2 #(
  parameter int unsigned     DataW    = 10,
  parameter logic [DataW-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o
);

  logic [1:0]       count_q, count_d;
  logic [DataW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic             push, pop;

  assign ready_o = (count_q != 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign push    = push_i & ready_o;
  assign pop     = pop_i & valid_o;
  assign rdata_o = ent0_q;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (pop && (count_q == 2'd2)) begin
      ent0_d = ent1_q;
    end
    // A push lands in the first slot left free after any simultaneous pop.
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        ent0_d = wdata_i;
      end else begin
        ent1_d = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      ent0_q  <= ResetVal;
      ent1_q  <= ResetVal;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise gate ALU with accumulator feedback and a two-entry valid/ready output buffer.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_par
);

  localparam int unsigned EntryW = WIDTH + 2;
  // An all-zero result carries y_zero=1.
  localparam logic [EntryW-1:0] EntryReset = EntryW'(2'b10);

  logic              accept;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  res_w;
  result_t           res;
  logic [EntryW-1:0] wdata, rdata;
  logic              unused_res_y;

  assign accept = in_valid & in_ready;

  always_comb begin
    b_eff = b;
    if (in_acc) begin
      b_eff = acc_clr ? '0 : acc_q;
    end
  end

  always_comb begin
    res_w = '0;
    unique case (op_e'(op))
      OpAnd:   res_w = a & b_eff;
      OpOr:    res_w = a | b_eff;
      OpXor:   res_w = a ^ b_eff;
      OpNand:  res_w = ~(a & b_eff);
      OpNor:   res_w = ~(a | b_eff);
      OpXnor:  res_w = ~(a ^ b_eff);
      OpNotA:  res_w = ~a;
      OpPassA: res_w = a;
    endcase
  end

  assign res          = make_result(MaxWidth'(res_w));
  assign wdata        = {res.y[WIDTH-1:0], res.y_zero, res.y_par};
  assign unused_res_y = ^res.y;

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = res_w;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  logic_gate_fifo2 #(
    .DataW    (EntryW),
    .ResetVal (EntryReset)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (in_valid),
    .wdata_i (wdata),
    .ready_o (in_ready),
    .valid_o (out_valid),
    .pop_i   (out_ready),
    .rdata_o (rdata)
  );

  assign {y, y_zero, y_par} = rdata;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: truth-table reference model plus a decoupled monitor.
module tb_logic_gate_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_acc = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         y_zero;
  logic         y_par;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .y_par     (y_par)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         p;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] model_acc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_gate(input logic [2:0] f, input logic [W-1:0] x,
                                            input logic [W-1:0] z);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (f)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic model_accept();
    logic [W-1:0] beff;
    logic [W-1:0] r;
    exp_t         e;
    if (!in_acc) beff = b;
    else if (acc_clr) beff = '0;
    else beff = model_acc;
    r   = ref_gate(op, a, beff);
    e.y = r;
    e.z = (r == '0);
    e.p = ($countones(r) % 2) == 1;
    exp_q.push_back(e);
    model_acc = r;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                      input logic tacc, input logic tclr, input bit rnd_rdy, output int waits);
    logic rdy;
    bit   done;
    done  = 0;
    waits = 0;
    a = ta; b = tb_; op = top; in_acc = tacc; acc_clr = tclr; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept();
        done = 1;
      end else begin
        waits++;
        if (tclr) model_acc = '0;
      end
      #1;
    end
    in_valid = 1'b0; acc_clr = 1'b0; in_acc = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    bit             hold_v;
    logic [W+1:0]   hold_val;
    exp_t           e;
    hold_v = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_v && out_valid) check("stall_hold", {y, y_zero, y_par}, hold_val);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("y", y, e.y);
            check("y_zero", y_zero, e.z);
            check("y_par", y_par, e.p);
          end
        end
        hold_v   = out_valid && !out_ready;
        hold_val = {y, y_zero, y_par};
      end else begin
        hold_v = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int w, w3;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y", y, 0);
    check("rst_y_zero", y_zero, 1);
    check("rst_y_par", y_par, 0);
    @(posedge clk); #1;

    // Op sweep with a free-running consumer: one result per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(8'hF0, 8'h3C, 3'(k), 1'b0, 1'b0, 1'b0, w);
      check("sweep_no_wait", w, 0);
    end
    @(negedge clk);
    check("sweep_last_valid", out_valid, 1);
    @(negedge clk);
    check("sweep_empty", out_valid, 0);
    @(posedge clk); #1;

    // Backpressure: two fill the buffer, the third is held.
    out_ready = 1'b0;
    send(8'h11, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w);
    check("bp_first_wait", w, 0);
    send(8'h22, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w);
    check("bp_second_wait", w, 0);
    @(negedge clk);
    check("bp_full_ready", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    check("bp_head", y, 8'h11);
    @(posedge clk); #1;
    fork
      send(8'h33, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w3);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_third_held", w3, 4);
    wait_drain("bp_drain");

    // Accumulator: clear on an idle cycle, then XOR 0x01 into it three times.
    acc_clr = 1'b1;
    @(posedge clk);
    model_acc = '0;
    #1 acc_clr = 1'b0;
    for (int k = 0; k < 3; k++) send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, w);
    // Clear coinciding with an accumulating accept, then read acc back through OR with 0.
    send(8'h55, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w);
    send(8'hAA, 8'h00, 3'd1, 1'b1, 1'b1, 1'b0, w);
    send(8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, w);
    // Flag corner cases.
    send(8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0, 1'b0, w);
    send(8'h07, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w);
    wait_drain("dir_drain");

    // Randomised traffic with a randomly stalling consumer.
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'b1, w);
    end
    out_ready = 1'b1;
    wait_drain("rand_drain");

    // Reset with a full buffer; handshakes in the reset cycle must be ignored.
    out_ready = 1'b0;
    send(8'h5A, 8'hC3, 3'd2, 1'b0, 1'b0, 1'b0, w);
    send(8'hA5, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    check("rst_pre_full", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 8'hFF; op = 3'd7;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_y", y, 0);
    check("mrst_y_zero", y_zero, 1);
    check("mrst_y_par", y_par, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    // Accumulator must also have been cleared by reset.
    send(8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, w);
    wait_drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
